pmvm: RTL and testbench
=======================

# pmvm

Parametrised matrix-vector multiply engine; successor to the fixed 4x4 `MVM` in the binarized-network wrapper. The block latches an input activation vector of C elements on `start`. It then accepts one weight column per handshake, R weights wide, and accumulates R signed dot products. When done it presents the result vector with a one-cycle done pulse. It sits between the batch-norm/activation stage and the next layer's input buffer.

## Interface
- `R`, 4: number of output rows (lanes), ≥1
- `C`, 4: number of columns (vector length), ≥2
- `XW`, 4: activation width, unsigned
- `WW`, 4: weight width, signed two's complement (ignored when binary mode compiled in)
- `AW`, XW+WW+$clog2(C): accumulator/result width, signed; derived, not overridden

- `i_clk_pmvm`  in  1  clock, rising edge
- `i_rst_pmvm`  in  1  reset, asynchronous, active-low
- `i_start_pmvm`  in  1  start request; sampled only in IDLE
- `i_x_pmvm`  in  C*XW  activation vector; element c at bits [c*XW +: XW]
- `i_w_valid_pmvm`  in  1  weight column valid
- `i_w_pmvm`  in  R*WW (R in binary mode)  weight column; row r at [r*WW +: WW]
- `o_w_ready_pmvm`  out  1  weight column accepted when valid & ready
- `o_busy_pmvm`  out  1  high in RUN and DONE
- `o_done_pmvm`  out  1  one-cycle pulse, results valid
- `o_result_pmvm`  out  R*AW  signed results; row r at [r*AW +: AW]

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `o_w_ready`=0. On `i_start`=1, latch `i_x` into the vector register, clear all R accumulators, clear the column counter, and go to RUN. `o_result` holds its previous value until the clear.
- RUN: `o_w_ready`=1. On each valid&ready, update acc[r] += x[col] * w[r] for every r in parallel. x is zero-extended and w is sign-extended to AW. Then increment col.
- When the accepted column is col==C-1, go to DONE. Weights with valid=0 stall without penalty.
- DONE: `o_done`=1 for exactly one cycle, `o_w_ready`=0, then go to IDLE.
- `o_result` mirrors the accumulators directly. It is valid and stable from DONE until the next accepted start.
- `i_start` in RUN or DONE is ignored. It is not queued.
- Changes on `i_x` after the start cycle have no effect.
- AW is sized so that no overflow is possible for any legal inputs. No saturation logic is required.
- Asynchronous reset asserted mid-operation aborts immediately. The block returns to IDLE with all state cleared. No done pulse is produced.

## Timing
- Reset values:
  - `o_w_ready`=0
  - `o_busy`=0
  - `o_done`=0
  - `o_result`=0
  - state=IDLE
  - counter=0
  - vector register=0
- Start sampled at edge 0. RUN begins after edge 0, so `o_w_ready`=1 in cycle 1.
- With valid held high, columns are accepted at edges 1..C. DONE is in cycle C+1, and `o_done` is high in that cycle.
- Minimum start-to-done latency is C+1 cycles. Each stalled cycle adds one.
- IDLE resumes at cycle C+2. A new start can be accepted at edge C+2. Back-to-back throughput is 1 vector per C+2 cycles.
- `o_busy` is high from cycle 1 through cycle C+1 inclusive.
- Accumulator update is a single-cycle multiply-add. There is no internal pipelining, so results are exact at the DONE cycle.

## Configuration
- `PMVM_BINARY_EN` defined:
  - `i_w_pmvm` is R bits, one bit per row.
  - Bit 1 means +x[col]; bit 0 means −x[col]. This is XNOR-style ±1 weighting with no multipliers.
  - WW is ignored, and AW = XW+1+$clog2(C).
- Not defined: full WW-bit signed multiply as described above.
- The handshake, the states and the timing are identical in both builds.

## Test plan
- Default parameters, all x=15, weight 7 in every row for 4 columns with valid held high: `o_done` in cycle 5, every result = 420, busy high in cycles 1–5.
- All x=15, all weights −8: every result = −480 (10-bit 0x220). This is the negative extreme with no overflow.
- Mixed row weights 1, −1, 0, 3 with x = 1, 2, 3, 4: results 10, −10, 0, 30.
- Valid toggled 1,0,0,1,1,0,1: done arrives exactly 3 cycles later than the no-stall case; results are unchanged.
- Start pulsed again in RUN, plus async reset after 2 columns: the second start is ignored; after reset all outputs are 0 and no done occurs; a fresh start then computes correctly.
- `PMVM_BINARY_EN` build, x all 15: weights all 1 give 60 per row; all 0 give −60; alternating 1010 per column gives 0.

Source files
------------

// File: rtl/pmvm.sv
// pmvm: parametrised matrix-vector multiply engine.
// Latches a C-element unsigned activation vector on start, then accepts one
// R-wide signed weight column per valid/ready handshake and accumulates R
// dot products. A one-cycle done pulse marks the result vector valid.
// Optional build macro: PMVM_BINARY_EN selects 1-bit +/-1 (XNOR-style)
// weights instead of WW-bit signed multiplies.
module pmvm #(
  parameter int R  = 4,
  parameter int C  = 4,
  parameter int XW = 4,
  parameter int WW = 4,
`ifdef PMVM_BINARY_EN
  localparam int WB = 1,
  localparam int AW = XW + 1 + $clog2(C)
`else
  localparam int WB = WW,
  localparam int AW = XW + WW + $clog2(C)
`endif
) (
  input  logic            i_clk_pmvm,
  input  logic            i_rst_pmvm,
  input  logic            i_start_pmvm,
  input  logic [C*XW-1:0] i_x_pmvm,
  input  logic            i_w_valid_pmvm,
  input  logic [R*WB-1:0] i_w_pmvm,
  output logic            o_w_ready_pmvm,
  output logic            o_busy_pmvm,
  output logic            o_done_pmvm,
  output logic [R*AW-1:0] o_result_pmvm
);

  localparam int CW = $clog2(C);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        col;
  logic [C*XW-1:0]      x_reg;
  logic signed [AW-1:0] acc  [R];
  logic signed [AW-1:0] term [R];
  logic signed [AW-1:0] x_ext;
  logic [XW-1:0]        x_sel;
  logic                 fire;
  logic                 col_last;

  assign fire     = (state == RUN) && i_w_valid_pmvm;
  assign col_last = (col == CW'(C - 1));
  assign x_sel    = x_reg[col*XW +: XW];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk_pmvm or negedge i_rst_pmvm) begin
    if (!i_rst_pmvm) state <= IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic: start only from IDLE, leave RUN on the last accepted column.
  // NOTE: default assignment first so no path leaves state_nxt unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start_pmvm)        state_nxt = RUN;
      RUN:     if (fire && col_last)    state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from state.
  always_comb begin
    o_w_ready_pmvm = (state == RUN);
    o_busy_pmvm    = (state != IDLE);
    o_done_pmvm    = (state == DONE);
  end

  // Per-row contribution of the current column: x zero-extended, w sign-extended.
  always_comb begin
    x_ext = AW'(x_sel);
    for (int r = 0; r < R; r++) begin
`ifdef PMVM_BINARY_EN
      term[r] = i_w_pmvm[r] ? x_ext : -x_ext;
`else
      term[r] = x_ext * AW'(signed'(i_w_pmvm[r*WW +: WW]));
`endif
    end
  end

  // Vector latch, column counter and accumulators.
  // NOTE: the accumulator array is small and its zero value is architecturally
  // visible on o_result, so it is reset along with the other registers.
  always_ff @(posedge i_clk_pmvm or negedge i_rst_pmvm) begin
    if (!i_rst_pmvm) begin
      col   <= '0;
      x_reg <= '0;
      for (int r = 0; r < R; r++) acc[r] <= '0;
    end else if (state == IDLE && i_start_pmvm) begin
      col   <= '0;
      x_reg <= i_x_pmvm;
      for (int r = 0; r < R; r++) acc[r] <= '0;
    end else if (fire) begin
      col <= col + CW'(1);
      for (int r = 0; r < R; r++) acc[r] <= acc[r] + term[r];
    end
  end

  // Result bus mirrors the accumulators.
  always_comb begin
    o_result_pmvm = '0;
    for (int r = 0; r < R; r++) o_result_pmvm[r*AW +: AW] = acc[r];
  end

endmodule

// File: tb/tb_pmvm.sv
// tb_pmvm: scoreboard bench for pmvm. Expected result vectors are pushed when
// a job is started and popped when the DUT pulses done.
module tb_pmvm;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int XW = 4;
  localparam int WW = 4;
`ifdef PMVM_BINARY_EN
  localparam int WB = 1;
  localparam int AW = XW + 1 + $clog2(C);
`else
  localparam int WB = WW;
  localparam int AW = XW + WW + $clog2(C);
`endif

  typedef logic [R*AW-1:0] res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [C*XW-1:0] x = '0;
  logic            w_valid = 1'b0;
  logic [R*WB-1:0] w = '0;
  logic            w_ready;
  logic            busy;
  logic            done;
  res_t            result;

  always #5 clk = ~clk;

  pmvm #(.R(R), .C(C), .XW(XW), .WW(WW)) dut (
    .i_clk_pmvm     (clk),
    .i_rst_pmvm     (rst_n),
    .i_start_pmvm   (start),
    .i_x_pmvm       (x),
    .i_w_valid_pmvm (w_valid),
    .i_w_pmvm       (w),
    .o_w_ready_pmvm (w_ready),
    .o_busy_pmvm    (busy),
    .o_done_pmvm    (done),
    .o_result_pmvm  (result)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  res_t exp_q[$];
  res_t last_exp = '0;

  // Current job: activations, weights per column/row, valid pattern.
  int          jx [C];
  int          jw [C][R];
  logic [15:0] vpat;
  int          vlen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [C*XW-1:0] pack_x();
    logic [C*XW-1:0] v;
    v = '0;
    for (int c = 0; c < C; c++) v[c*XW +: XW] = XW'(jx[c]);
    return v;
  endfunction

  function automatic logic [R*WB-1:0] pack_w(input int c);
    logic [R*WB-1:0] v;
    v = '0;
    for (int r = 0; r < R; r++) v[r*WB +: WB] = WB'(jw[c][r]);
    return v;
  endfunction

  // Reference model: plain integer dot products.
  function automatic res_t model();
    res_t v;
    int   s;
    v = '0;
    for (int r = 0; r < R; r++) begin
      s = 0;
      for (int c = 0; c < C; c++) begin
`ifdef PMVM_BINARY_EN
        s += (jw[c][r] != 0) ? jx[c] : -jx[c];
`else
        s += jx[c] * jw[c][r];
`endif
      end
      v[r*AW +: AW] = AW'(s);
    end
    return v;
  endfunction

  // Scoreboard consumer: compare every row on each done pulse.
  always @(negedge clk) begin
    res_t e;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        for (int r = 0; r < R; r++)
          check($sformatf("row%0d", r), 64'(result[r*AW +: AW]), 64'(e[r*AW +: AW]));
      end
    end
  end

  // Run one job; stalls = number of valid=0 cycles in vpat before the last column.
  task automatic run_job(input string name, input int stalls, input int restart_at);
    int   k;
    int   col;
    int   p;
    logic busy_ok;
    last_exp = model();
    exp_q.push_back(last_exp);
    @(negedge clk);
    start = 1'b1;
    x     = pack_x();
    @(posedge clk); #1;
    start = 1'b0;
    x     = ~x;
    col = 0; p = 0; k = 1; busy_ok = 1'b1;
    while (k < 64) begin
      start = (k == restart_at);
      if (col < C && (p >= vlen || vpat[p])) begin
        w_valid = 1'b1;
        w       = pack_w(col);
      end else begin
        w_valid = 1'b0;
        w       = ~w;
      end
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) break;
      if (w_valid && w_ready) col++;
      p++;
      @(posedge clk); #1;
      k++;
    end
    start   = 1'b0;
    w_valid = 1'b0;
    check({name, "_done_cycle"}, 64'(k), 64'(C + 1 + stalls));
    check({name, "_busy_run"}, 64'(busy_ok), 1);
    check({name, "_ready_in_done"}, 64'(w_ready), 0);
    @(negedge clk);
    @(negedge clk);
    check({name, "_busy_after"}, 64'(busy), 0);
    check({name, "_result_hold"}, 64'(result), 64'(last_exp));
  endtask

  task automatic fill(input int xv [C], input int wv [R], input logic alt);
    for (int c = 0; c < C; c++) begin
      jx[c] = xv[c];
      for (int r = 0; r < R; r++) jw[c][r] = (alt && c[0]) ? 0 : wv[r];
    end
  endtask

  initial begin
    int dc;
    vpat = '0;
    vlen = 0;
    #12;
    check("rst_ready", 64'(w_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PMVM_BINARY_EN
    fill('{15, 15, 15, 15}, '{1, 1, 1, 1}, 1'b0);
    run_job("bin_plus", 0, 0);
    fill('{15, 15, 15, 15}, '{0, 0, 0, 0}, 1'b0);
    run_job("bin_minus", 0, 0);
    fill('{15, 15, 15, 15}, '{1, 1, 1, 1}, 1'b1);
    run_job("bin_alt", 0, 0);
    fill('{1, 2, 3, 4}, '{1, 0, 1, 0}, 1'b0);
`else
    fill('{15, 15, 15, 15}, '{7, 7, 7, 7}, 1'b0);
    run_job("max_pos", 0, 0);
    fill('{15, 15, 15, 15}, '{-8, -8, -8, -8}, 1'b0);
    run_job("max_neg", 0, 0);
    fill('{1, 2, 3, 4}, '{1, -1, 0, 3}, 1'b0);
    run_job("mixed", 0, 0);
`endif

    // Stalled handshake: 1,0,0,1,1,0,1 adds three cycles.
    vpat = 16'b0000_0000_0101_1001;
    vlen = 7;
    run_job("stall", 3, 0);
    vlen = 0;

    // Start re-pulsed during RUN must be ignored.
    fill('{3, 5, 7, 9}, '{2, 1, 1, 2}, 1'b0);
    run_job("restart", 0, 2);

    // Async reset after two accepted columns aborts without a done pulse.
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1;
    x     = pack_x();
    @(posedge clk); #1;
    start   = 1'b0;
    w_valid = 1'b1;
    w       = pack_w(0);
    @(posedge clk); #1;
    w = pack_w(1);
    @(posedge clk); #1;
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(w_ready), 0);
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_result", 64'(result), 0);
    start   = 1'b0;
    w_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - dc), 0);
    check("abort_idle_busy", 64'(busy), 0);

    // Fresh job after the abort.
    fill('{15, 14, 13, 12}, '{-8, 7, -3, 1}, 1'b0);
    run_job("post_reset", 0, 0);

    check("sb_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
